// File: rtl/pucch_cs_ctrl_pkg.sv
// pucch_pkg: shared types and defaults for the PUCCH format 0 cyclic-shift controller
package pucch_pkg;
  localparam int CYC_DIV_DEF = 24;
  localparam int NSYM_MAX_DEF = 14;
  typedef logic [4:0] cyc_t;
  typedef logic [3:0] sym_t;
  typedef enum logic {CS_IDLE, CS_RUN} cs_state_t;
  localparam cyc_t BPSK_OFF = cyc_t'(CYC_DIV_DEF / 2);
endpackage

// File: rtl/pucch_cs_ctrl_if.sv
// pucch_cs_ctrl_if: request, n_cs lookup and per-symbol output stream of the cyclic-shift controller
interface pucch_cs_ctrl_if;
  import pucch_pkg::*;
  logic i_req_valid;
  logic o_req_ready;
  logic [1:0] i_b;
  logic i_nbits;
  cyc_t i_m0;
  sym_t i_sym0;
  sym_t i_nsym;
  sym_t o_ncs_sym;
  cyc_t i_ncs;
  logic o_valid;
  logic i_ready;
  cyc_t o_cyc;
  sym_t o_sym;
  logic o_last;
  modport master (
    output i_req_valid, i_b, i_nbits, i_m0, i_sym0, i_nsym, i_ncs, i_ready,
    input o_req_ready, o_ncs_sym, o_valid, o_cyc, o_sym, o_last
  );
  modport slave (
    input i_req_valid, i_b, i_nbits, i_m0, i_sym0, i_nsym, i_ncs, i_ready,
    output o_req_ready, o_ncs_sym, o_valid, o_cyc, o_sym, o_last
  );
endinterface

// File: rtl/pucch_cs_ctrl_qpsk_cyc.sv
// qpsk_cyc: Gray-mapped QPSK HARQ bits to cycle-part offset (odd eighths of a cycle)
module qpsk_cyc
  import pucch_pkg::*;
#(
  parameter int CYC_DIV = CYC_DIV_DEF
) (
  input  logic [1:0] i_b,
  output cyc_t       o_m
);
  assign o_m = cyc_t'(CYC_DIV * (i_b[1] ? (i_b[0] ? 5 : 7) : (i_b[0] ? 3 : 1)) / 8);
endmodule

// File: rtl/pucch_cs_ctrl.sv
// pucch_cs_ctrl: sequences per-symbol PUCCH format 0 cyclic shifts over a valid/ready stream.
// Define PUCCH_CS_CTRL_NCS_EN to add the external hopping offset i_ncs into the sum.
module pucch_cs_ctrl
  import pucch_pkg::*;
#(
  parameter int CYC_DIV = CYC_DIV_DEF,
  parameter int NSYM_MAX = NSYM_MAX_DEF
) (
  input logic i_clk,
  input logic i_rst,
  pucch_cs_ctrl_if.slave bus
);
  cs_state_t state_q, state_d;
  sym_t cnt_q, cnt_d, sym_q, sym_d, osym_q, osym_d;
  cyc_t m0_q, m0_d, mcs_q, mcs_d, cyc_q, cyc_d, qpsk_m, ncs, red;
  logic valid_q, valid_d, last_q, last_d;
  logic take, load, acc;
  logic [6:0] s, s1;
  qpsk_cyc #(.CYC_DIV(CYC_DIV)) u_qpsk (.i_b(bus.i_b), .o_m(qpsk_m));
`ifdef PUCCH_CS_CTRL_NCS_EN
  assign ncs = bus.i_ncs;
`else
  logic unused_ncs;
  assign unused_ncs = ^bus.i_ncs;
  assign ncs = '0;
`endif
  always_comb begin
    take = (state_q == CS_IDLE) & bus.i_req_valid;
    acc = valid_q & bus.i_ready;
    load = (state_q == CS_RUN) & (cnt_q != '0) & (~valid_q | bus.i_ready);
    s = 7'(m0_q) + 7'(mcs_q) + 7'(ncs);
    s1 = (s >= 7'(CYC_DIV)) ? s - 7'(CYC_DIV) : s;
    red = cyc_t'((s1 >= 7'(CYC_DIV)) ? s1 - 7'(CYC_DIV) : s1);
    state_d = take ? CS_RUN : (acc & last_q) ? CS_IDLE : state_q;
    cnt_d = take ? ((bus.i_nsym == '0) ? 4'd1 : (bus.i_nsym > 4'(NSYM_MAX)) ? 4'(NSYM_MAX) : bus.i_nsym)
          : load ? cnt_q - 4'd1 : cnt_q;
    sym_d = take ? ((bus.i_sym0 >= 4'(NSYM_MAX)) ? bus.i_sym0 - 4'(NSYM_MAX) : bus.i_sym0)
          : load ? ((sym_q == 4'(NSYM_MAX - 1)) ? '0 : sym_q + 4'd1) : sym_q;
    m0_d = take ? bus.i_m0 : m0_q;
    mcs_d = take ? (bus.i_nbits ? qpsk_m : (bus.i_b[0] ? cyc_t'(CYC_DIV / 2) : '0)) : mcs_q;
    valid_d = load | (valid_q & ~bus.i_ready);
    cyc_d = load ? red : cyc_q;
    osym_d = load ? sym_q : osym_q;
    last_d = load ? (cnt_q == 4'd1) : acc ? 1'b0 : last_q;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= CS_IDLE;
      cnt_q <= '0;
      sym_q <= '0;
      m0_q <= '0;
      mcs_q <= '0;
      valid_q <= 1'b0;
      cyc_q <= '0;
      osym_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sym_q <= sym_d;
      m0_q <= m0_d;
      mcs_q <= mcs_d;
      valid_q <= valid_d;
      cyc_q <= cyc_d;
      osym_q <= osym_d;
      last_q <= last_d;
    end
  assign bus.o_req_ready = (state_q == CS_IDLE);
  assign bus.o_ncs_sym = sym_q;
  assign bus.o_valid = valid_q;
  assign bus.o_cyc = cyc_q;
  assign bus.o_sym = osym_q;
  assign bus.o_last = last_q;
endmodule

// File: tb/tb_pucch_cs_ctrl.sv
// tb_pucch_cs_ctrl: directed self-checking bench for pucch_cs_ctrl
module tb_pucch_cs_ctrl;
  import pucch_pkg::*;
`ifdef PUCCH_CS_CTRL_NCS_EN
  localparam bit NCS_EN = 1'b1;
`else
  localparam bit NCS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] ncs_tab [16];
  pucch_cs_ctrl_if bus();
  pucch_cs_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.i_ncs = ncs_tab[bus.o_ncs_sym];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ncs(input logic [4:0] v);
    for (int i = 0; i < 16; i++) ncs_tab[i] = v;
  endtask

  task automatic send_req(input logic [1:0] b, input logic nb, input logic [4:0] m0, input logic [3:0] s0, input logic [3:0] n);
    bus.i_b = b; bus.i_nbits = nb; bus.i_m0 = m0; bus.i_sym0 = s0; bus.i_nsym = n;
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_b = ~b; bus.i_nbits = ~nb; bus.i_m0 = 5'd17; bus.i_sym0 = ~s0; bus.i_nsym = 4'd9;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", bus.o_valid); end
    n_chk++; if (bus.o_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %0b want 0", bus.o_last); end
    n_chk++; if (bus.o_cyc !== 5'd0) begin n_fail++; $display("FAIL rst_cyc: got %0d want 0", bus.o_cyc); end
    n_chk++; if (bus.o_sym !== 4'd0) begin n_fail++; $display("FAIL rst_sym: got %0d want 0", bus.o_sym); end
    n_chk++; if (bus.o_ncs_sym !== 4'd0) begin n_fail++; $display("FAIL rst_ncs_sym: got %0d want 0", bus.o_ncs_sym); end
    n_chk++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b want 1", bus.o_req_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_qpsk_ncs();
    fill_ncs(5'd0);
    ncs_tab[2] = 5'd6; ncs_tab[3] = 5'd10;
    send_req(2'b10, 1'b1, 5'd4, 4'd2, 4'd2);
    n_chk++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL qpsk_busy: got %0b want 0", bus.o_req_ready); end
    n_chk++; if (bus.o_ncs_sym !== 4'd2) begin n_fail++; $display("FAIL qpsk_ncs_sym: got %0d want 2", bus.o_ncs_sym); end
    tick();
    n_chk++; if (bus.o_valid !== 1'b1 || bus.o_sym !== 4'd2 || bus.o_last !== 1'b0) begin n_fail++; $display("FAIL qpsk_s0: got v%0b sym%0d l%0b want v1 sym2 l0", bus.o_valid, bus.o_sym, bus.o_last); end
    n_chk++; if (bus.o_cyc !== (NCS_EN ? 5'd7 : 5'd1)) begin n_fail++; $display("FAIL qpsk_cyc0: got %0d want %0d", bus.o_cyc, NCS_EN ? 7 : 1); end
    tick();
    n_chk++; if (bus.o_valid !== 1'b1 || bus.o_sym !== 4'd3 || bus.o_last !== 1'b1) begin n_fail++; $display("FAIL qpsk_s1: got v%0b sym%0d l%0b want v1 sym3 l1", bus.o_valid, bus.o_sym, bus.o_last); end
    n_chk++; if (bus.o_cyc !== (NCS_EN ? 5'd11 : 5'd1)) begin n_fail++; $display("FAIL qpsk_cyc1: got %0d want %0d", bus.o_cyc, NCS_EN ? 11 : 1); end
    tick();
    n_chk++; if (bus.o_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL qpsk_done: got v%0b rdy%0b want v0 rdy1", bus.o_valid, bus.o_req_ready); end
  endtask

  task automatic test_bpsk();
    fill_ncs(5'd0);
    send_req(2'b11, 1'b0, 5'd0, 4'd5, 4'd1);
    tick();
    n_chk++; if (bus.o_cyc !== 5'd12 || bus.o_sym !== 4'd5 || bus.o_last !== 1'b1) begin n_fail++; $display("FAIL bpsk: got cyc%0d sym%0d l%0b want cyc12 sym5 l1", bus.o_cyc, bus.o_sym, bus.o_last); end
    tick();
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bpsk_done: got %0b want 0", bus.o_valid); end
    send_req(2'b10, 1'b0, 5'd3, 4'd0, 4'd1);
    tick();
    n_chk++; if (bus.o_cyc !== 5'd3) begin n_fail++; $display("FAIL bpsk_zero: got %0d want 3", bus.o_cyc); end
    tick();
  endtask

  task automatic test_double_wrap();
    fill_ncs(5'd23);
    send_req(2'b00, 1'b1, 5'd23, 4'd0, 4'd1);
    tick();
    n_chk++; if (bus.o_cyc !== (NCS_EN ? 5'd1 : 5'd2)) begin n_fail++; $display("FAIL double_wrap: got %0d want %0d", bus.o_cyc, NCS_EN ? 1 : 2); end
    tick();
  endtask

  task automatic test_sym_wrap();
    int cnt;
    logic [3:0] ls;
    fill_ncs(5'd0);
    send_req(2'b00, 1'b0, 5'd0, 4'd13, 4'd2);
    n_chk++; if (bus.o_ncs_sym !== 4'd13) begin n_fail++; $display("FAIL wrap_ncs_sym: got %0d want 13", bus.o_ncs_sym); end
    tick();
    n_chk++; if (bus.o_sym !== 4'd13 || bus.o_last !== 1'b0) begin n_fail++; $display("FAIL wrap_s0: got sym%0d l%0b want sym13 l0", bus.o_sym, bus.o_last); end
    tick();
    n_chk++; if (bus.o_sym !== 4'd0 || bus.o_last !== 1'b1) begin n_fail++; $display("FAIL wrap_s1: got sym%0d l%0b want sym0 l1", bus.o_sym, bus.o_last); end
    tick();
    send_req(2'b00, 1'b0, 5'd0, 4'd15, 4'd0);
    tick();
    n_chk++; if (bus.o_valid !== 1'b1 || bus.o_sym !== 4'd1 || bus.o_last !== 1'b1) begin n_fail++; $display("FAIL nsym0: got v%0b sym%0d l%0b want v1 sym1 l1", bus.o_valid, bus.o_sym, bus.o_last); end
    tick();
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL nsym0_done: got %0b want 0", bus.o_valid); end
    send_req(2'b00, 1'b0, 5'd0, 4'd3, 4'd15);
    cnt = 0;
    ls = 4'hf;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.o_valid) cnt++;
      if (bus.o_valid && bus.o_last) begin ls = bus.o_sym; break; end
    end
    n_chk++; if (cnt != 14 || ls !== 4'd2) begin n_fail++; $display("FAIL clamp: got cnt%0d last_sym%0d want cnt14 last_sym2", cnt, ls); end
    tick();
  endtask

  task automatic test_backpressure();
    fill_ncs(5'd0);
    send_req(2'b01, 1'b1, 5'd7, 4'd4, 4'd3);
    tick();
    n_chk++; if (bus.o_sym !== 4'd4 || bus.o_cyc !== 5'd16) begin n_fail++; $display("FAIL bp_s0: got sym%0d cyc%0d want sym4 cyc16", bus.o_sym, bus.o_cyc); end
    tick();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.o_valid !== 1'b1 || bus.o_sym !== 4'd5 || bus.o_cyc !== 5'd16 || bus.o_last !== 1'b0 || bus.o_ncs_sym !== 4'd6) begin n_fail++; $display("FAIL bp_hold%0d: got v%0b sym%0d cyc%0d l%0b nsym%0d want v1 sym5 cyc16 l0 nsym6", i, bus.o_valid, bus.o_sym, bus.o_cyc, bus.o_last, bus.o_ncs_sym); end
    end
    bus.i_ready = 1'b1;
    tick();
    n_chk++; if (bus.o_sym !== 4'd6 || bus.o_last !== 1'b1 || bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s2: got sym%0d l%0b rdy%0b want sym6 l1 rdy0", bus.o_sym, bus.o_last, bus.o_req_ready); end
    tick();
    n_chk++; if (bus.o_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_done: got v%0b rdy%0b want v0 rdy1", bus.o_valid, bus.o_req_ready); end
  endtask

  task automatic test_reset_mid();
    fill_ncs(5'd0);
    send_req(2'b00, 1'b0, 5'd0, 4'd0, 4'd4);
    repeat (3) tick();
    n_chk++; if (bus.o_sym !== 4'd2) begin n_fail++; $display("FAIL rm_pre: got sym%0d want 2", bus.o_sym); end
    rst = 1'b1;
    #1;
    n_chk++; if (bus.o_valid !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_ncs_sym !== 4'd0 || bus.o_sym !== 4'd0) begin n_fail++; $display("FAIL rm_async: got v%0b rdy%0b nsym%0d sym%0d want v0 rdy1 nsym0 sym0", bus.o_valid, bus.o_req_ready, bus.o_ncs_sym, bus.o_sym); end
    tick();
    rst = 1'b0;
    tick();
    n_chk++; if (bus.o_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_no_resume: got v%0b rdy%0b want v0 rdy1", bus.o_valid, bus.o_req_ready); end
    send_req(2'b00, 1'b0, 5'd0, 4'd9, 4'd1);
    tick();
    n_chk++; if (bus.o_sym !== 4'd9 || bus.o_last !== 1'b1) begin n_fail++; $display("FAIL rm_restart: got sym%0d l%0b want sym9 l1", bus.o_sym, bus.o_last); end
    tick();
  endtask

  task automatic test_back_to_back();
    fill_ncs(5'd0);
    bus.i_b = 2'b00; bus.i_nbits = 1'b0; bus.i_m0 = 5'd2; bus.i_sym0 = 4'd7; bus.i_nsym = 4'd1;
    bus.i_req_valid = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.o_valid !== 1'b1 || bus.o_sym !== 4'd7 || bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got v%0b sym%0d rdy%0b want v1 sym7 rdy0", bus.o_valid, bus.o_sym, bus.o_req_ready); end
    bus.i_m0 = 5'd5; bus.i_sym0 = 4'd8;
    tick();
    n_chk++; if (bus.o_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got v%0b rdy%0b want v0 rdy1", bus.o_valid, bus.o_req_ready); end
    tick();
    bus.i_req_valid = 1'b0;
    n_chk++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got rdy%0b want 0", bus.o_req_ready); end
    tick();
    n_chk++; if (bus.o_sym !== 4'd8 || bus.o_cyc !== 5'd5) begin n_fail++; $display("FAIL b2b_second: got sym%0d cyc%0d want sym8 cyc5", bus.o_sym, bus.o_cyc); end
    tick();
  endtask

  initial begin
    bus.i_req_valid = 1'b0; bus.i_b = '0; bus.i_nbits = 1'b0; bus.i_m0 = '0;
    bus.i_sym0 = '0; bus.i_nsym = '0; bus.i_ready = 1'b1;
    fill_ncs(5'd0);
    test_reset();
    test_qpsk_ncs();
    test_bpsk();
    test_double_wrap();
    test_sym_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pucch_cs_ctrl.md
# pucch_cs_ctrl

Sequences the per-symbol cyclic-shift computation for PUCCH format 0 across the allocated OFDM symbols. It accepts one UCI request (1–2 HARQ bits, initial cyclic shift, symbol allocation) and maps the bits to a cycle-part offset through an instantiated `qpsk_cyc` (or a BPSK rule for 1 bit). It then emits one cyclic-shift value per symbol over a valid/ready stream to the sequence-generation datapath. A per-symbol hopping offset `n_cs` comes from an external combinational lookup that is indexed by the block.

## Interface
- `CYC_DIV`, 24: number of parts in one cycle; must be at most 32 (5-bit cycle-part width).
- `NSYM_MAX`, 14: symbols per slot; bounds the symbol index and the count.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; one clock domain, asynchronous and active-high.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  request accepted when high with `i_req_valid`.
- `i_b`  in  2  HARQ bits; only `i_b[0]` is used when `i_nbits`=0.
- `i_nbits`  in  1  0 = 1 bit (BPSK), 1 = 2 bits (QPSK).
- `i_m0`  in  5  initial cyclic shift in cycle parts, 0..CYC_DIV-1.
- `i_sym0`  in  4  first symbol index.
- `i_nsym`  in  4  number of symbols.
- `o_ncs_sym`  out  4  symbol index driven to the n_cs lookup.
- `i_ncs`  in  5  n_cs for `o_ncs_sym`, same cycle, 0..CYC_DIV-1.
- `o_valid`  out  1  output symbol valid.
- `i_ready`  in  1  downstream accepts.
- `o_cyc`  out  5  cyclic shift in cycle parts, 0..CYC_DIV-1.
- `o_sym`  out  4  symbol index of `o_cyc`.
- `o_last`  out  1  final symbol of the request.

## Operation
- FSM has two states.
  - IDLE: `o_req_ready`=1.
  - RUN: `o_req_ready`=0.
- IDLE → RUN on `i_req_valid & o_req_ready`. The request fields and the computed m_cs are latched at that edge.
- m_cs, 2 bits: the `qpsk_cyc` output. For CYC_DIV=24 this gives 00→3, 01→9, 10→21, 11→15.
- m_cs, 1 bit: `i_b[0]`=0 → 0; `i_b[0]`=1 → CYC_DIV/2.
- Symbol count:
  - `i_nsym`=0 is treated as 1.
  - `i_nsym`>NSYM_MAX is clamped to NSYM_MAX.
- Symbol index starts at `i_sym0` and increments per symbol. It wraps from NSYM_MAX-1 to 0, and any `i_sym0` ≥ NSYM_MAX is reduced modulo NSYM_MAX.
- `o_ncs_sym` always shows the index of the next symbol to be loaded.
- Arithmetic: s = m0 + m_cs + n_cs in 7 bits. It is reduced by at most two conditional subtractions of CYC_DIV, giving a result in 0..CYC_DIV-1.
- The output register loads a new symbol whenever it is empty or its current symbol is accepted.
- `o_last`=1 with the final symbol. Acceptance of the last symbol returns the FSM to IDLE at that edge.
- A new request cannot be accepted in the same cycle as the last-symbol acceptance.

## Timing
- Reset values:
  - `o_valid`=0, `o_last`=0, `o_cyc`=0, `o_sym`=0.
  - `o_ncs_sym`=0, `o_req_ready`=1, FSM=IDLE.
- Request accepted at edge T → first `o_valid`=1 at T+1.
- With `i_ready` held high, one symbol is output per cycle. An N-symbol request occupies cycles T+1..T+N, and `o_req_ready` returns to 1 at T+N+1.
- Backpressure: while `o_valid & ~i_ready`, `o_cyc`, `o_sym` and `o_last` hold stable and the symbol counter does not advance.
- `o_valid` never drops without acceptance.
- Asserting `i_rst` mid-request immediately forces reset values. The request is discarded and is not resumed.
- `i_b`, `i_m0`, `i_sym0`, `i_nsym` and `i_nbits` are sampled only at the accepting edge.

## Configuration
- `PUCCH_CS_CTRL_NCS_EN` defined: `i_ncs` is added into the sum as described.
- `PUCCH_CS_CTRL_NCS_EN` undefined: `i_ncs` is ignored and treated as 0; `o_ncs_sym` is still driven.
- Ports and timing are identical in both builds.

## Structure
- Shared package `pucch_pkg` holds:
  - the state enum (`CS_IDLE`, `CS_RUN`);
  - the `CYC_DIV` and `NSYM_MAX` defaults;
  - the 5-bit cycle-part typedef;
  - the BPSK offset constant.
- One sub-module: `qpsk_cyc`, instantiated with `CYC_DIV` passed through.
- Modulo reduction and the symbol counter stay inline.

## Test plan
- QPSK offset plus n_cs:
  - Stimulus: b=10, nbits=1, m0=4, sym0=2, nsym=2, n_cs(2)=6, n_cs(3)=10, `i_ready` held high.
  - Response: (sym 2, cyc 7), then (sym 3, cyc 11, last).
- BPSK mapping:
  - Stimulus: nbits=0, b[0]=1, m0=0, n_cs=0, nsym=1.
  - Response: cyc 12, last.
- Double wrap of the sum:
  - Stimulus: m0=23, b=00, n_cs=23.
  - Response: s=49 → cyc 1.
- Symbol wrap and clamping:
  - sym0=13, nsym=2 → symbols 13 then 0.
  - nsym=0 → exactly one symbol.
- Backpressure:
  - Stimulus: hold `i_ready`=0 for 3 cycles on symbol 1 of 3.
  - Response: outputs stable, no symbol skipped; `o_req_ready` rises one cycle after the last acceptance.
- Reset mid-run:
  - Stimulus: assert `i_rst` after the second of 4 symbols.
  - Response: `o_valid`=0 immediately, `o_req_ready`=1 after release; the next request starts cleanly at its own sym0.
